// File: rtl/spi_master.sv
// Mode-0 SPI master issuing one addressed register read or write per start request.
// Frame: lead 0, address, rw, then read turnaround + capture or write data + commit cycles.
module spi_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int CYCLE_TO_WRITE = 2,
  parameter int CLK_DIV        = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     rw,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    data_write,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    data_read,
  output logic                     SCK,
  output logic                     SS,
  output logic                     MOSI,
  input  logic                     MISO
);

  // state | meaning
  // IDLE  | waiting for start, SS high
  // SETUP | SS low, SCK low for one half-period
  // XFER  | SCK toggling, one bit per period
  // HOLD  | SS still low after the last SCK fall
  // GAP   | SS high before returning to IDLE with done
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

  localparam int N_RD  = ADDRESS_WIDTH + DATA_WIDTH + 3;
  localparam int N_WR  = ADDRESS_WIDTH + DATA_WIDTH + 2 + CYCLE_TO_WRITE;
  localparam int N_MAX = (N_RD > N_WR) ? N_RD : N_WR;
  localparam int FW    = ADDRESS_WIDTH + DATA_WIDTH + 3 + CYCLE_TO_WRITE;
  localparam int BW    = $clog2(N_MAX + 1);
  localparam int DVW   = $clog2(CLK_DIV + 1);

  localparam logic [DVW-1:0] DIV_LOAD  = DVW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  LAST_RD   = BW'(N_RD - 1);
  localparam logic [BW-1:0]  LAST_WR   = BW'(N_WR - 1);
  localparam logic [BW-1:0]  CAP_FIRST = BW'(ADDRESS_WIDTH + 3);

  state_t                  state_q, state_d;
  logic [DVW-1:0]          div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   data_read_q, data_read_d;
  logic                    rw_q, rw_d;
  logic                    sck_q, sck_d;
  logic                    ss_q, ss_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    div_tc;
  logic [BW-1:0]           last_bit;
  logic [DATA_WIDTH-1:0]   payload;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      rd_q        <= '0;
      data_read_q <= '0;
      rw_q        <= 1'b0;
      sck_q       <= 1'b0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      rd_q        <= rd_d;
      data_read_q <= data_read_d;
      rw_q        <= rw_d;
      sck_q       <= sck_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    rd_d        = rd_q;
    data_read_d = data_read_q;
    rw_d        = rw_q;
    sck_d       = sck_q;
    ss_d        = ss_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_tc      = (div_q == '0);
    last_bit    = rw_q ? LAST_RD : LAST_WR;
    payload     = rw ? '0 : data_write;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Reads send zeros after rw; the extra zero covers the read turnaround.
          frame_d = {1'b0, address, rw, payload, {(CYCLE_TO_WRITE + 1){1'b0}}};
          rw_d    = rw;
          div_d   = DIV_LOAD;
          bit_d   = '0;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_tc) begin
          div_d   = DIV_LOAD;
          sck_d   = 1'b1;
          mosi_d  = frame_q[FW-1];
          frame_d = frame_q << 1;
          state_d = S_XFER;
        end else begin
          div_d = div_q - DVW'(1);
        end
      end
      S_XFER: begin
        if (div_tc) begin
          div_d = DIV_LOAD;
          if (sck_q) begin
            sck_d = 1'b0;
            if (rw_q && (bit_q >= CAP_FIRST)) rd_d = {rd_q[DATA_WIDTH-2:0], MISO};
            if (bit_q == last_bit) begin
              mosi_d  = 1'b0;
              state_d = S_HOLD;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            sck_d   = 1'b1;
            mosi_d  = frame_q[FW-1];
            frame_d = frame_q << 1;
          end
        end else begin
          div_d = div_q - DVW'(1);
        end
      end
      S_HOLD: begin
        if (div_tc) begin
          div_d   = DIV_LOAD;
          ss_d    = 1'b1;
          state_d = S_GAP;
        end else begin
          div_d = div_q - DVW'(1);
        end
      end
      S_GAP: begin
        if (div_tc) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (rw_q) data_read_d = rd_q;
          state_d = S_IDLE;
        end else begin
          div_d = div_q - DVW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign data_read = data_read_q;
  assign SCK       = sck_q;
  assign SS        = ss_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: small 8/8 instance with CLK_DIV=2 and a default-width
// instance with CLK_DIV=1 talking to a register-slave model.
module tb_spi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- instance A: AW=8 DW=8 CTW=2 CLK_DIV=2 ----------------
  logic       a_rst_n = 1'b0, a_start = 1'b0, a_rw = 1'b0, a_miso = 1'b0;
  logic       a_busy, a_done, a_sck, a_ss, a_mosi;
  logic [7:0] a_addr = '0, a_wdata = '0, a_miso_word = '0;
  logic [7:0] a_rdata;

  spi_master #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .CYCLE_TO_WRITE(2), .CLK_DIV(2)) u_a (
    .clk(clk), .reset_n(a_rst_n), .start(a_start), .rw(a_rw), .address(a_addr),
    .data_write(a_wdata), .busy(a_busy), .done(a_done), .data_read(a_rdata),
    .SCK(a_sck), .SS(a_ss), .MOSI(a_mosi), .MISO(a_miso));

  // Slave for A drives a_miso_word MSB first from the rise of period 11.
  int a_per = 0;
  always @(posedge a_sck or posedge a_ss) begin
    if (a_ss) a_per = 0;
    else begin
      if (a_per >= 11 && a_per < 19) a_miso = a_miso_word[7 - (a_per - 11)];
      else a_miso = 1'b0;
      a_per++;
    end
  end

  // ---------------- instance B: defaults, CLK_DIV=1 ----------------
  logic        b_rst_n = 1'b0, b_start = 1'b0, b_rw = 1'b0, b_miso = 1'b0;
  logic        b_busy, b_done, b_sck, b_ss, b_mosi;
  logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;

  spi_master #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .CYCLE_TO_WRITE(2), .CLK_DIV(1)) u_b (
    .clk(clk), .reset_n(b_rst_n), .start(b_start), .rw(b_rw), .address(b_addr),
    .data_write(b_wdata), .busy(b_busy), .done(b_done), .data_read(b_rdata),
    .SCK(b_sck), .SS(b_ss), .MOSI(b_mosi), .MISO(b_miso));

  // Register slave for B: decodes MOSI on SCK falls, drives MISO on SCK rises.
  logic [31:0] b_mem [16];
  logic [31:0] b_ash = '0, b_wsh = '0, b_rword = '0;
  logic        b_rwbit = 1'b0;
  int b_pr = 0, b_pf = 0;

  always @(posedge b_sck or posedge b_ss) begin
    if (b_ss) b_pr = 0;
    else begin
      if (b_pr >= 35 && b_pr < 67) b_miso = b_rword[31 - (b_pr - 35)];
      else b_miso = 1'b0;
      b_pr++;
    end
  end

  always @(negedge b_sck or posedge b_ss) begin
    if (b_ss) b_pf = 0;
    else begin
      if (b_pf >= 1 && b_pf <= 32) b_ash = {b_ash[30:0], b_mosi};
      else if (b_pf == 33) begin
        b_rwbit = b_mosi;
        b_rword = b_mem[b_ash[3:0]];
      end else if (b_pf >= 34 && b_pf <= 65 && !b_rwbit) begin
        b_wsh = {b_wsh[30:0], b_mosi};
        if (b_pf == 65) b_mem[b_ash[3:0]] = b_wsh;
      end
      b_pf++;
    end
  end

  // ---------------- vectors for A ----------------
  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  miso;
    logic [19:0] mosi;   // MOSI at each rise, period 0 in bit 19
    int          rises;
    int          lat;    // cycles from accepting edge to done
    logic [7:0]  dr;     // data_read at done
  } vec_t;

  vec_t vecs [5];

  task automatic run_a(input int idx, input vec_t v);
    int          rises;
    int          done_k;
    logic        prev_sck;
    logic [19:0] got;
    rises = 0; done_k = -1; prev_sck = 1'b0; got = '0;
    @(negedge clk);
    a_rw = v.rw; a_addr = v.addr; a_wdata = v.wdata; a_miso_word = v.miso; a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (k == 1) begin
        chk($sformatf("v%0d ss_at_t1", idx), a_ss, 1'b0);
        chk($sformatf("v%0d busy_at_t1", idx), a_busy, 1'b1);
      end
      if (a_sck && !prev_sck) begin
        if (rises < 20) got[19 - rises] = a_mosi;
        rises++;
      end
      prev_sck = a_sck;
      if (a_done) begin
        done_k = k;
        chk($sformatf("v%0d busy_at_done", idx), a_busy, 1'b0);
        chk($sformatf("v%0d data_read", idx), a_rdata, v.dr);
        chk($sformatf("v%0d ss_at_done", idx), a_ss, 1'b1);
      end
    end
    chk($sformatf("v%0d done_latency", idx), done_k, v.lat);
    chk($sformatf("v%0d sck_rises", idx), rises, v.rises);
    chk($sformatf("v%0d mosi_bits", idx), got, v.mosi);
    @(posedge clk);
    #1 chk($sformatf("v%0d done_one_cycle", idx), a_done, 1'b0);
  endtask

  task automatic run_b(input string name, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input logic [31:0] dr);
    int done_k;
    done_k = -1;
    @(negedge clk);
    b_rw = rw; b_addr = addr; b_wdata = wdata; b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (b_done) done_k = k;
    end
    chk({name, " done_latency"}, done_k, lat);
    chk({name, " data_read"}, b_rdata, dr);
    @(posedge clk);
    #1 chk({name, " done_fall"}, b_done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rises, dones, ss_hi, k;
    logic prev_sck, second, seen;

    for (int i = 0; i < 16; i++) b_mem[i] = '0;

    vecs[0] = '{1'b0, 8'h3C, 8'hA5, 8'h00, 20'b0_00111100_0_10100101_00, 20, 85, 8'h00};
    vecs[1] = '{1'b1, 8'h81, 8'h00, 8'hC3, 20'b0_10000001_1_0_00000000_0, 19, 81, 8'hC3};
    vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'h00, 20'b0_11111111_0_00000000_00, 20, 85, 8'hC3};
    vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h5A, 20'b0_00000000_1_0_00000000_0, 19, 81, 8'h5A};
    vecs[4] = '{1'b0, 8'h01, 8'h80, 8'h00, 20'b0_00000001_0_10000000_00, 20, 85, 8'h5A};

    repeat (3) @(posedge clk);
    #1;
    chk("reset ss", a_ss, 1'b1);
    chk("reset sck", a_sck, 1'b0);
    chk("reset mosi", a_mosi, 1'b0);
    chk("reset busy", a_busy, 1'b0);
    chk("reset done", a_done, 1'b0);
    chk("reset data_read", a_rdata, 8'h00);
    @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) run_a(i, vecs[i]);

    // Mid-frame reset at the rise of period 5 of a write.
    @(negedge clk);
    a_rw = 1'b0; a_addr = 8'h3C; a_wdata = 8'hA5; a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    rises = 0; prev_sck = 1'b0;
    for (k = 0; k < 100 && rises < 6; k++) begin
      @(posedge clk);
      #1;
      if (a_sck && !prev_sck) rises++;
      prev_sck = a_sck;
    end
    chk("midreset reached_period5", rises, 6);
    #2 a_rst_n = 1'b0;
    #1;
    chk("midreset ss", a_ss, 1'b1);
    chk("midreset sck", a_sck, 1'b0);
    chk("midreset mosi", a_mosi, 1'b0);
    chk("midreset busy", a_busy, 1'b0);
    chk("midreset done", a_done, 1'b0);
    chk("midreset data_read", a_rdata, 8'h00);
    @(negedge clk);
    a_rst_n = 1'b1;
    rises = 0; prev_sck = 1'b0; seen = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      if (a_sck && !prev_sck) rises++;
      prev_sck = a_sck;
      if (!a_ss || a_busy) seen = 1'b1;
    end
    chk("postreset sck_rises", rises, 0);
    chk("postreset ss_or_busy_active", seen, 1'b0);
    run_a(5, vecs[0]);

    // Start held high through a read: one frame, one done, then a re-trigger.
    @(negedge clk);
    a_rw = 1'b1; a_addr = 8'h22; a_miso_word = 8'h69; a_start = 1'b1;
    for (k = 0; k < 20 && a_ss; k++) begin
      @(posedge clk);
      #1;
    end
    chk("ignored first_ss_fall", a_ss, 1'b0);
    dones = 0; rises = 0; ss_hi = 0; second = 1'b0; prev_sck = a_sck;
    for (k = 0; k < 200 && !second; k++) begin
      @(posedge clk);
      #1;
      if (a_done) dones++;
      if (a_sck && !prev_sck) rises++;
      prev_sck = a_sck;
      if (a_ss) ss_hi++;
      else if (ss_hi > 0) second = 1'b1;
    end
    a_start = 1'b0;
    chk("ignored second_frame_seen", second, 1'b1);
    chk("ignored done_pulses", dones, 1);
    chk("ignored sck_rises", rises, 19);
    chk("ignored ss_high_ge_clkdiv", (ss_hi >= 2), 1'b1);
    chk("ignored ss_high_le_clkdiv_plus1", (ss_hi <= 3), 1'b1);
    chk("ignored data_read", a_rdata, 8'h69);
    seen = 1'b0;
    for (k = 0; k < 200 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (a_done) seen = 1'b1;
    end
    chk("ignored second_done", seen, 1'b1);

    // Minimum divider against the register slave.
    run_b("b write7", 1'b0, 32'h7, 32'hDEADBEEF, 139, 32'h0);
    run_b("b write3", 1'b0, 32'h3, 32'h12345678, 139, 32'h0);
    run_b("b read7", 1'b1, 32'h7, 32'h0, 137, 32'hDEADBEEF);
    run_b("b read3", 1'b1, 32'h3, 32'h0, 137, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
